// File: rtl/cla16_pkg.sv
// Shared types and sizing for the 16-bit carry-lookahead adder/subtractor.
package cla16_pkg;

  localparam int WIDTH  = 16;
  localparam int GROUP  = 4;
  localparam int NGROUP = 4;

  typedef logic [WIDTH-1:0] word_t;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Per-bit generate/propagate from one operand bit pair.
  function automatic gp_t bit_gp(input logic a, input logic b);
    gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/cla4_group.sv
// First-level 4-bit lookahead group: local carries, sum bits, and group G/P
// for the second-level unit.
module cla4_group
  import cla16_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c0,
  output logic [GROUP-1:0] s,
  output logic             G,
  output logic             P
);

  gp_t [GROUP-1:0] gp;
  logic [GROUP-1:0] c;

  always_comb begin
    for (int i = 0; i < GROUP; i++) gp[i] = bit_gp(a[i], b[i]);
  end

  // Flattened lookahead: every carry is a two-level function of c0 and g/p.
  always_comb begin
    c[0] = c0;
    c[1] = gp[0].g | (gp[0].p & c0);
    c[2] = gp[1].g | (gp[1].p & gp[0].g) | (gp[1].p & gp[0].p & c0);
    c[3] = gp[2].g | (gp[2].p & gp[1].g) | (gp[2].p & gp[1].p & gp[0].g)
         | (gp[2].p & gp[1].p & gp[0].p & c0);
  end

  always_comb begin
    for (int i = 0; i < GROUP; i++) s[i] = gp[i].p ^ c[i];
  end

  assign G = gp[3].g | (gp[3].p & gp[2].g) | (gp[3].p & gp[2].p & gp[1].g)
           | (gp[3].p & gp[2].p & gp[1].p & gp[0].g);
  assign P = gp[3].p & gp[2].p & gp[1].p & gp[0].p;

endmodule

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder/subtractor, registered outputs.
// Define CLA16_OVF_EN to add the registered signed-overflow output ovf.
module cla_16bit
  import cla16_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  word_t ain,
  input  word_t bin,
  input  logic  cin,
  input  logic  sub,
  output word_t sum,
  output logic  cout
`ifdef CLA16_OVF_EN
  ,
  output logic  ovf
`endif
);

  word_t              b_eff;
  word_t              sum_nxt;
  logic               c0;
  logic [NGROUP-1:0]  grp_g;
  logic [NGROUP-1:0]  grp_p;
  logic [NGROUP:0]    gc;

  // Subtract is a + ~b + 1; the external carry-in is not used then.
  assign b_eff = bin ^ {WIDTH{sub}};
  assign c0    = sub | cin;

  for (genvar gi = 0; gi < NGROUP; gi++) begin : g_grp
    cla4_group u_grp (
      .a  (ain[gi*GROUP +: GROUP]),
      .b  (b_eff[gi*GROUP +: GROUP]),
      .c0 (gc[gi]),
      .s  (sum_nxt[gi*GROUP +: GROUP]),
      .G  (grp_g[gi]),
      .P  (grp_p[gi])
    );
  end

  // Second-level lookahead: group carries c4/c8/c12/c16 straight from c0.
  always_comb begin
    gc[0] = c0;
    gc[1] = grp_g[0] | (grp_p[0] & c0);
    gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c0);
    gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[2] & grp_p[1] & grp_p[0] & c0);
    gc[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_nxt;
      cout <= gc[NGROUP];
    end
  end

`ifdef CLA16_OVF_EN
  logic ovf_nxt;

  // Overflow judged on the effective operand, so subtract needs no special case.
  assign ovf_nxt = (ain[WIDTH-1] == b_eff[WIDTH-1]) && (sum_nxt[WIDTH-1] != ain[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= ovf_nxt;
  end
`endif

endmodule

// File: tb/tb_cla_16bit.sv
// Self-checking bench for cla_16bit: reset, directed vectors, random sweep.
module tb_cla_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] ain, bin;
  logic        cin, sub;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA16_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  cla_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ain   (ain),
    .bin   (bin),
    .cin   (cin),
    .sub   (sub),
    .sum   (sum),
    .cout  (cout)
`ifdef CLA16_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive at negedge, result visible just after the following posedge.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    @(negedge clk);
    ain = a; bin = b; cin = c; sub = s;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [15:0] a, b;
    logic        c, s;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add_0_0",       16'd0,     16'd0,     1'b0, 1'b0, 16'd0,     1'b0, 1'b0});
    vecs.push_back('{"add_7fff_8000", 16'd32767, 16'd32768, 1'b0, 1'b0, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{"add_ovf",       16'd32767, 16'd16384, 1'b0, 1'b0, 16'd49151, 1'b0, 1'b1});
    vecs.push_back('{"sub_100_50",    16'd100,   16'd50,    1'b0, 1'b1, 16'd50,    1'b1, 1'b0});
    vecs.push_back('{"sub_50_30",     16'd50,    16'd30,    1'b0, 1'b1, 16'd20,    1'b1, 1'b0});
    vecs.push_back('{"sub_100_100",   16'd100,   16'd100,   1'b0, 1'b1, 16'd0,     1'b1, 1'b0});
    vecs.push_back('{"sub_borrow",    16'd50,    16'd100,   1'b0, 1'b1, 16'd65486, 1'b0, 1'b0});
    vecs.push_back('{"add_cin",       16'd8,     16'd8,     1'b1, 1'b0, 16'd17,    1'b0, 1'b0});
    vecs.push_back('{"sub_cin_ign",   16'd15,    16'd7,     1'b1, 1'b1, 16'd8,     1'b1, 1'b0});
    vecs.push_back('{"sub_cin0",      16'd15,    16'd7,     1'b0, 1'b1, 16'd8,     1'b1, 1'b0});
    vecs.push_back('{"add_wrap",      16'hFFFF,  16'h0001,  1'b0, 1'b0, 16'h0000,  1'b1, 1'b0});
    vecs.push_back('{"add_0fff_1",    16'h0FFF,  16'h0001,  1'b0, 1'b0, 16'h1000,  1'b0, 1'b0});
    vecs.push_back('{"sub_0_1",       16'h0000,  16'h0001,  1'b0, 1'b1, 16'hFFFF,  1'b0, 1'b0});
    vecs.push_back('{"sub_min_1",     16'h8000,  16'h0001,  1'b0, 1'b1, 16'h7FFF,  1'b1, 1'b1});
    vecs.push_back('{"add_cin_ripple",16'h7FFF,  16'h0000,  1'b1, 1'b0, 16'h8000,  1'b0, 1'b1});
  end

  initial begin
    rst_n = 1'b0;
    ain = 16'($urandom); bin = 16'($urandom); cin = 1'b1; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef CLA16_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    // Release with a pending op; output stays 0 until the next edge.
    @(negedge clk);
    rst_n = 1'b1; ain = 16'd3; bin = 16'd4; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rel_pre_edge", 32'(sum), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_first", 32'(sum), 32'd7);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);
      chk({vecs[i].tag, "_sum"}, 32'(sum), 32'(vecs[i].es));
      chk({vecs[i].tag, "_cout"}, 32'(cout), 32'(vecs[i].ec));
`ifdef CLA16_OVF_EN
      chk({vecs[i].tag, "_ovf"}, 32'(ovf), 32'(vecs[i].eo));
`endif
    end

    // Mid-operation reset clears outputs without waiting for an edge.
    apply(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 10000; n++) begin
      logic [15:0] a, b;
      logic        c, s;
      logic [16:0] ref_r;
      int          sr;
      logic        ref_o;
      a = 16'($urandom); b = 16'($urandom);
      c = 1'($urandom); s = 1'($urandom);
      if (s) begin
        ref_r = {1'b0, a} + {1'b0, ~b} + 17'd1;
        sr = $signed(a) - $signed(b);
      end else begin
        ref_r = {1'b0, a} + {1'b0, b} + 17'(c);
        sr = $signed(a) + $signed(b) + int'(c);
      end
      ref_o = (sr > 32767) || (sr < -32768);
      apply(a, b, c, s);
      chk("rnd_sum_cout", {15'd0, cout, sum}, {15'd0, ref_r});
`ifdef CLA16_OVF_EN
      chk("rnd_ovf", 32'(ovf), 32'(ref_o));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
